f2_sprite_render: RTL and testbench
===================================

# f2_sprite_render

Pixel-pipeline stage that sits directly upstream of the F2 sprite VRAM and downstream of the VGA timing generator. Each pixel it converts the raster position into a 16x16 sprite address plus animation frame index for the VRAM, then takes the VRAM's 3-bit RGB pixel back and drives the final RGB and delayed syncs to the DAC pins. Owns sprite position latching, optional integer scaling, and frame-based animation stepping.

## Interface
- SCALE_LOG2, 0, sprite magnification as a power of two (0..3); on-screen extent is 16<<SCALE_LOG2 per axis
- FRAME_DIV, 30, video frames per animation step (1..255)
- NUM_IMAGES, 2, number of animation frames cycled (1..8)

- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- pix_en  in  1  pixel-clock enable; all pipeline and counter state advances only when high
- hcount  in  10  raster column from timing generator
- vcount  in  10  raster line from timing generator
- video_on  in  1  visible-area flag
- hsync_in  in  1  horizontal sync, active low
- vsync_in  in  1  vertical sync, active low
- pos_x  in  10  sprite left edge, sampled at frame start
- pos_y  in  10  sprite top edge, sampled at frame start
- bg_color  in  3  background RGB outside sprite
- pixel_addr  out  8  VRAM address {row[3:0], col[3:0]}
- image_index  out  3  VRAM animation frame select
- pixel_data  in  3  VRAM RGB, combinational from pixel_addr/image_index
- rgb_out  out  3  final {R,G,B}
- hsync_out  out  1  hsync delayed to match rgb_out
- vsync_out  out  1  vsync delayed to match rgb_out

## Operation
- Frame start: pix_en && hcount==0 && vcount==0. On it: latch pos_x/pos_y into px_q/py_q; advance frame counter.
- Frame counter 8 bits, counts 0..FRAME_DIV-1; on wrap image_index increments, wrapping NUM_IMAGES-1 -> 0. image_index changes only at frame start (no mid-frame tearing).
- Stage 1 (pix_en): dx = hcount - px_q, dy = vcount - py_q computed in 11 bits; hit = hcount>=px_q && vcount>=py_q && dx < (16<<SCALE_LOG2) && dy < (16<<SCALE_LOG2). pixel_addr <= {dy[SCALE_LOG2+3:SCALE_LOG2], dx[SCALE_LOG2+3:SCALE_LOG2]} when hit, else unchanged. Register hit, video_on, hsync_in, vsync_in.
- Stage 2 (pix_en): rgb_out <= !von1 ? 3'b000 : hit1 ? pixel_data : bg_color. hsync_out/vsync_out <= stage-1 copies.
- Sprite partially past right/bottom edge clips naturally; pos_x+extent overflow handled by 11-bit compare.
- pix_en low: every register holds.

## Timing
- Reset (rst_n low at clk edge): rgb_out=0, pixel_addr=0, image_index=0, hsync_out=1, vsync_out=1, frame counter=0, px_q=py_q=0, pipeline flags cleared. Reset mid-frame: outputs forced immediately on that edge; resumes on next pix_en after release, animation restarts at image 0.
- Latency: rgb_out/syncs reflect hcount/vcount presented two pix_en strobes earlier; syncs and rgb always aligned.
- pixel_addr/image_index valid one strobe after input; VRAM result consumed in the following strobe.
- FRAME_DIV=1: image_index advances every frame. NUM_IMAGES=1: image_index stays 0.
- pos_x/pos_y changes outside frame start have no effect until the next frame start.

## Configuration
- SPRITE_TRANSPARENCY_EN defined: pixel_data==3'b111 inside the sprite is treated as transparent and rgb_out takes bg_color.
- Not defined: pixel_data drives rgb_out unmodified whenever hit.

## Test plan
- Reset, pos=(100,50), SCALE_LOG2=0, pixel_data tied 3'b010, bg 3'b001 -> at (100,50) rgb_out=3'b010 two strobes later, pixel_addr=0; at (115,65) pixel_addr=255; at (116,50) rgb_out=3'b001.
- video_on low inside sprite -> rgb_out=3'b000; hsync_in low pulse at strobe N -> hsync_out low at strobe N+2.
- FRAME_DIV=2, NUM_IMAGES=2, run 5 frames -> image_index 0,0,1,1,0 per frame, changing only at frame start.
- SCALE_LOG2=1, pos=(0,0) -> (2,2) gives pixel_addr=0x11, (31,31) gives 0xFF, (32,0) misses.
- With SPRITE_TRANSPARENCY_EN, pixel_data=3'b111 in sprite, bg=3'b100 -> rgb_out=3'b100; without macro -> 3'b111.
- Assert rst_n low mid-frame with image_index=1 -> next edge rgb_out=0, syncs=1, image_index=0; pos_y changed mid-frame -> sprite moves only from next frame.

Source files
------------

// File: rtl/f2_sprite_render_if.sv
// Raster-in / VRAM / DAC signal bundle for f2_sprite_render.
// master: timing generator + VRAM + DAC side; slave: the sprite renderer.
interface f2_sprite_render_if;
    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [2:0] bg_color;
    logic [7:0] pixel_addr;
    logic [2:0] image_index;
    logic [2:0] pixel_data;
    logic [2:0] rgb_out;
    logic       hsync_out;
    logic       vsync_out;

    modport master (
        output pix_en, hcount, vcount, video_on, hsync_in, vsync_in,
               pos_x, pos_y, bg_color, pixel_data,
        input  pixel_addr, image_index, rgb_out, hsync_out, vsync_out
    );

    modport slave (
        input  pix_en, hcount, vcount, video_on, hsync_in, vsync_in,
               pos_x, pos_y, bg_color, pixel_data,
        output pixel_addr, image_index, rgb_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/f2_sprite_render.sv
// Two-stage sprite pixel pipeline: raster -> VRAM address/frame, VRAM RGB -> DAC.
// Define SPRITE_TRANSPARENCY_EN to treat VRAM colour 3'b111 as transparent.
module f2_sprite_render #(
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned FRAME_DIV  = 30,
    parameter int unsigned NUM_IMAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    f2_sprite_render_if.slave  bus
);
    localparam int unsigned CW       = 11;
    localparam int unsigned EXTENT   = 16 << SCALE_LOG2;
    localparam logic [CW-1:0] EXT_W  = CW'(EXTENT);
    localparam logic [7:0] FDIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [2:0] IMG_LAST  = 3'(NUM_IMAGES - 1);

    logic [9:0]    px_q;
    logic [9:0]    py_q;
    logic [7:0]    frame_cnt;
    logic          hit1;
    logic          von1;
    logic          hs1;
    logic          vs1;
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic          hit;
    logic          frame_start;
    logic          sprite_vis;

    // 11-bit offsets keep sprites hanging past column/line 1023 from aliasing
    always_comb begin
        dx          = {1'b0, bus.hcount} - {1'b0, px_q};
        dy          = {1'b0, bus.vcount} - {1'b0, py_q};
        hit         = (bus.hcount >= px_q) && (bus.vcount >= py_q) &&
                      (dx < EXT_W) && (dy < EXT_W);
        frame_start = bus.pix_en && (bus.hcount == 10'd0) && (bus.vcount == 10'd0);
    end

`ifdef SPRITE_TRANSPARENCY_EN
    assign sprite_vis = hit1 && (bus.pixel_data != 3'b111);
`else
    assign sprite_vis = hit1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            px_q            <= 10'd0;
            py_q            <= 10'd0;
            frame_cnt       <= 8'd0;
            hit1            <= 1'b0;
            von1            <= 1'b0;
            hs1             <= 1'b1;
            vs1             <= 1'b1;
            bus.pixel_addr  <= 8'd0;
            bus.image_index <= 3'd0;
            bus.rgb_out     <= 3'd0;
            bus.hsync_out   <= 1'b1;
            bus.vsync_out   <= 1'b1;
        end else if (bus.pix_en) begin
            // stage 1: address generation and flag alignment
            if (hit) begin
                bus.pixel_addr <= {dy[SCALE_LOG2 +: 4], dx[SCALE_LOG2 +: 4]};
            end
            hit1 <= hit;
            von1 <= bus.video_on;
            hs1  <= bus.hsync_in;
            vs1  <= bus.vsync_in;

            // stage 2: colour select with syncs kept in step
            bus.rgb_out   <= !von1      ? 3'b000 :
                             sprite_vis ? bus.pixel_data : bus.bg_color;
            bus.hsync_out <= hs1;
            bus.vsync_out <= vs1;

            // position latch and animation only move at frame start
            if (frame_start) begin
                px_q <= bus.pos_x;
                py_q <= bus.pos_y;
                if (frame_cnt >= FDIV_LAST) begin
                    frame_cnt       <= 8'd0;
                    bus.image_index <= (bus.image_index >= IMG_LAST) ? 3'd0
                                                                     : bus.image_index + 3'd1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_f2_sprite_render.sv
// Bench for f2_sprite_render: two parameterisations driven in lockstep, a frame-level
// reference model, a vector table, directed corner sequences and random raster traffic.
module tb_f2_sprite_render;
    localparam int unsigned SA = 0, FA = 2, NA = 2;
    localparam int unsigned SB = 1, FB = 1, NB = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       pix_en, von, hs, vs;
    logic [9:0] hcount, vcount, pos_x, pos_y;
    logic [2:0] bg;
    logic       tie_en;
    logic [2:0] tie_val;

    int compared = 0;
    int mismatched = 0;

    function automatic logic [2:0] vram(input logic [7:0] a, input logic [2:0] img,
                                        input logic te, input logic [2:0] tv);
        if (te) return tv;
        return 3'(a[2:0] + a[7:5] + a[4:3] + img);
    endfunction

    f2_sprite_render_if ifa ();
    f2_sprite_render_if ifb ();

    assign ifa.pix_en = pix_en;   assign ifb.pix_en = pix_en;
    assign ifa.hcount = hcount;   assign ifb.hcount = hcount;
    assign ifa.vcount = vcount;   assign ifb.vcount = vcount;
    assign ifa.video_on = von;    assign ifb.video_on = von;
    assign ifa.hsync_in = hs;     assign ifb.hsync_in = hs;
    assign ifa.vsync_in = vs;     assign ifb.vsync_in = vs;
    assign ifa.pos_x = pos_x;     assign ifb.pos_x = pos_x;
    assign ifa.pos_y = pos_y;     assign ifb.pos_y = pos_y;
    assign ifa.bg_color = bg;     assign ifb.bg_color = bg;
    assign ifa.pixel_data = vram(ifa.pixel_addr, ifa.image_index, tie_en, tie_val);
    assign ifb.pixel_data = vram(ifb.pixel_addr, ifb.image_index, tie_en, tie_val);

    f2_sprite_render #(.SCALE_LOG2(SA), .FRAME_DIV(FA), .NUM_IMAGES(NA)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    f2_sprite_render #(.SCALE_LOG2(SB), .FRAME_DIV(FB), .NUM_IMAGES(NB)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    // Reference model: frames seen since reset decide the animation frame directly.
    int         m_px[2], m_py[2], m_frames[2];
    logic [7:0] m_addr[2];
    logic [2:0] m_img[2], m_rgb[2];
    logic       m_hit1[2], m_von1[2], m_hs1[2], m_vs1[2], m_hso[2], m_vso[2];

    function automatic int scl(int d);  return (d == 0) ? SA : SB; endfunction
    function automatic int fdiv(int d); return (d == 0) ? FA : FB; endfunction
    function automatic int nimg(int d); return (d == 0) ? NA : NB; endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_px[d] = 0; m_py[d] = 0; m_frames[d] = 0;
            m_addr[d] = 8'd0; m_img[d] = 3'd0; m_rgb[d] = 3'd0;
            m_hit1[d] = 1'b0; m_von1[d] = 1'b0;
            m_hs1[d] = 1'b1; m_vs1[d] = 1'b1; m_hso[d] = 1'b1; m_vso[d] = 1'b1;
        end
    endtask

    task automatic model_step(input int d);
        logic [2:0] pix;
        logic       opaque;
        int         ext, dx, dy;
        pix = vram(m_addr[d], m_img[d], tie_en, tie_val);
`ifdef SPRITE_TRANSPARENCY_EN
        opaque = (pix != 3'b111);
`else
        opaque = 1'b1;
`endif
        m_rgb[d] = !m_von1[d] ? 3'b000 : (m_hit1[d] && opaque) ? pix : bg;
        m_hso[d] = m_hs1[d];
        m_vso[d] = m_vs1[d];
        ext = 16 << scl(d);
        dx  = int'(hcount) - m_px[d];
        dy  = int'(vcount) - m_py[d];
        m_hit1[d] = (dx >= 0) && (dy >= 0) && (dx < ext) && (dy < ext);
        if (m_hit1[d])
            m_addr[d] = {4'((dy >> scl(d)) % 16), 4'((dx >> scl(d)) % 16)};
        m_von1[d] = von; m_hs1[d] = hs; m_vs1[d] = vs;
        if (hcount == 10'd0 && vcount == 10'd0) begin
            m_px[d] = int'(pos_x);
            m_py[d] = int'(pos_y);
            m_frames[d]++;
            m_img[d] = 3'((m_frames[d] / fdiv(d)) % nimg(d));
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        check("model_rgb_a",  int'(ifa.rgb_out),     int'(m_rgb[0]));
        check("model_hs_a",   int'(ifa.hsync_out),   int'(m_hso[0]));
        check("model_vs_a",   int'(ifa.vsync_out),   int'(m_vso[0]));
        check("model_addr_a", int'(ifa.pixel_addr),  int'(m_addr[0]));
        check("model_img_a",  int'(ifa.image_index), int'(m_img[0]));
        check("model_rgb_b",  int'(ifb.rgb_out),     int'(m_rgb[1]));
        check("model_hs_b",   int'(ifb.hsync_out),   int'(m_hso[1]));
        check("model_vs_b",   int'(ifb.vsync_out),   int'(m_vso[1]));
        check("model_addr_b", int'(ifb.pixel_addr),  int'(m_addr[1]));
        check("model_img_b",  int'(ifb.image_index), int'(m_img[1]));
    endtask

    // One clock edge with the given raster inputs; outputs sampled 1 unit after the edge.
    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic on,
                        input logic hsn, input logic vsn, input logic en);
        hcount = h; vcount = v; von = on; hs = hsn; vs = vsn; pix_en = en;
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (en) begin model_step(0); model_step(1); end
        #1;
        model_check();
    endtask

    task automatic filler();
        step(10'd600, 10'd400, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(10'd7, 10'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        step(10'd7, 10'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       on;
        logic       hsn;
        logic [7:0] addr;
        logic [2:0] rgb;
        logic       hso;
    } vec_t;

    vec_t tbl[8];
    int   exp_a[5];
    int   exp_b[5];
    logic [2:0] exp_t;

    initial begin
        tbl[0] = '{10'd100, 10'd50, 1'b1, 1'b1, 8'h00, 3'b010, 1'b1};
        tbl[1] = '{10'd115, 10'd65, 1'b1, 1'b1, 8'hFF, 3'b010, 1'b1};
        tbl[2] = '{10'd116, 10'd50, 1'b1, 1'b1, 8'hFF, 3'b001, 1'b1};
        tbl[3] = '{10'd99,  10'd50, 1'b1, 1'b1, 8'hFF, 3'b001, 1'b1};
        tbl[4] = '{10'd105, 10'd50, 1'b0, 1'b1, 8'h05, 3'b000, 1'b1};
        tbl[5] = '{10'd103, 10'd52, 1'b1, 1'b0, 8'h23, 3'b010, 1'b0};
        tbl[6] = '{10'd100, 10'd66, 1'b1, 1'b1, 8'h23, 3'b001, 1'b1};
        tbl[7] = '{10'd110, 10'd60, 1'b1, 1'b1, 8'hAA, 3'b010, 1'b1};
        exp_a = '{0, 0, 1, 1, 0};
        exp_b = '{0, 1, 2, 0, 1};

        rst_n = 1'b1; tie_en = 1'b1; tie_val = 3'b010; bg = 3'b001;
        pos_x = 10'd100; pos_y = 10'd50;
        hcount = 10'd0; vcount = 10'd0; von = 1'b0; hs = 1'b1; vs = 1'b1; pix_en = 1'b0;
        model_reset();
        do_reset();

        check("rst_rgb",  int'(ifa.rgb_out), 0);
        check("rst_hs",   int'(ifa.hsync_out), 1);
        check("rst_vs",   int'(ifa.vsync_out), 1);
        check("rst_addr", int'(ifa.pixel_addr), 0);
        check("rst_img",  int'(ifa.image_index), 0);

        // latch pos=(100,50) then walk the vector table on the unscaled instance
        step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].h, tbl[i].v, tbl[i].on, tbl[i].hsn, 1'b1, 1'b1);
            check($sformatf("tbl%0d_addr", i), int'(ifa.pixel_addr), int'(tbl[i].addr));
            filler();
            check($sformatf("tbl%0d_rgb", i), int'(ifa.rgb_out), int'(tbl[i].rgb));
            check($sformatf("tbl%0d_hs", i), int'(ifa.hsync_out), int'(tbl[i].hso));
        end

        // hsync low for one strobe appears two strobes later
        step(10'd600, 10'd400, 1'b1, 1'b0, 1'b1, 1'b1);
        check("hs_lat_n0", int'(ifa.hsync_out), 1);
        filler();
        check("hs_lat_n1", int'(ifa.hsync_out), 0);
        filler();
        check("hs_lat_n2", int'(ifa.hsync_out), 1);

        // white VRAM pixel inside the sprite
        tie_val = 3'b111; bg = 3'b100;
`ifdef SPRITE_TRANSPARENCY_EN
        exp_t = 3'b100;
`else
        exp_t = 3'b111;
`endif
        step(10'd100, 10'd50, 1'b1, 1'b1, 1'b1, 1'b1);
        filler();
        check("transp_rgb", int'(ifa.rgb_out), int'(exp_t));

        // pix_en low: everything holds
        step(10'd115, 10'd65, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_addr", int'(ifa.pixel_addr), 8'h00);
        check("hold_rgb",  int'(ifa.rgb_out), int'(exp_t));
        check("hold_hs",   int'(ifa.hsync_out), 1);

        // 2x scaled instance at pos=(0,0)
        tie_val = 3'b010; bg = 3'b001; pos_x = 10'd0; pos_y = 10'd0;
        step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(10'd2, 10'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        check("scale_2_2", int'(ifb.pixel_addr), 8'h11);
        step(10'd31, 10'd31, 1'b1, 1'b1, 1'b1, 1'b1);
        check("scale_31_31", int'(ifb.pixel_addr), 8'hFF);
        step(10'd32, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("scale_32_0_addr", int'(ifb.pixel_addr), 8'hFF);
        filler();
        check("scale_32_0_rgb", int'(ifb.rgb_out), 3'b001);

        // animation stepping across five frames
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("anim_a%0d", i), int'(ifa.image_index), exp_a[i]);
            check($sformatf("anim_b%0d", i), int'(ifb.image_index), exp_b[i]);
            step(10'd40, 10'd3, 1'b1, 1'b1, 1'b1, 1'b1);
            step(10'd0, 10'd7, 1'b1, 1'b1, 1'b1, 1'b1);
            check($sformatf("anim_mid_a%0d", i), int'(ifa.image_index), exp_a[i]);
            step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        end

        // reset mid-frame while showing image 1
        do_reset();
        step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("pre_rst_img", int'(ifa.image_index), 1);
        step(10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        step(10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        check("pre_rst_rgb", int'(ifa.rgb_out), 3'b010);
        rst_n = 1'b0;
        step(10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        check("mid_rst_rgb", int'(ifa.rgb_out), 0);
        check("mid_rst_hs",  int'(ifa.hsync_out), 1);
        check("mid_rst_vs",  int'(ifa.vsync_out), 1);
        check("mid_rst_img", int'(ifa.image_index), 0);

        // pos_y moved mid-frame takes effect only after the next frame start
        pos_y = 10'd200;
        step(10'd2, 10'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        check("posy_old", int'(ifa.pixel_addr), 8'h22);
        step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(10'd5, 10'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        check("posy_miss", int'(ifa.pixel_addr), 8'h00);
        step(10'd4, 10'd203, 1'b1, 1'b1, 1'b1, 1'b1);
        check("posy_new", int'(ifa.pixel_addr), 8'h34);

        // random raster traffic against the model
        tie_en = 1'b0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [9:0] h, v;
            if ($urandom_range(0, 99) < 5) begin
                pos_x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1000, 1023))
                                                    : 10'($urandom_range(0, 200));
                pos_y = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1000, 1023))
                                                    : 10'($urandom_range(0, 120));
            end
            bg = 3'($urandom);
            h  = 10'(int'(pos_x) + $urandom_range(0, 45) - 5);
            v  = 10'(int'(pos_y) + $urandom_range(0, 45) - 5);
            if ($urandom_range(0, 3) == 0) begin h = 10'($urandom); v = 10'($urandom); end
            if ($urandom_range(0, 39) == 0) begin h = 10'd0; v = 10'd0; end
            if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            step(h, v, 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0));
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
